// File: rtl/mem_stage_if.sv
`default_nettype none
// mem_stage_if: EX->MEM inputs, DMEM and UART side-band signals, and MEM->WB outputs of mem_stage.
// slave = the MEM stage itself, master = the surrounding pipeline / environment.
interface mem_stage_if #(
    parameter int DMEM_AW = 14
);
    logic [31:0]        mem_pc;
    logic [31:0]        mem_alu;
    logic [31:0]        mem_rd2;
    logic [31:0]        mem_inst;
    logic               mem_br_suc;
    logic               dmem_en;
    logic [3:0]         dmem_we;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [31:0]        dmem_din;
    logic [7:0]         uart_tx_data;
    logic               uart_tx_valid;
    logic               uart_tx_ready;
    logic [7:0]         uart_rx_data;
    logic               uart_rx_valid;
    logic               uart_rx_ready;
    logic [31:0]        wb_pc;
    logic [31:0]        wb_alu;
    logic [31:0]        wb_inst;
    logic               wb_mmio;
    logic [31:0]        wb_mmio_rdata;

    modport slave (
        input  mem_pc, mem_alu, mem_rd2, mem_inst, mem_br_suc,
        input  uart_tx_ready, uart_rx_data, uart_rx_valid,
        output dmem_en, dmem_we, dmem_addr, dmem_din,
        output uart_tx_data, uart_tx_valid, uart_rx_ready,
        output wb_pc, wb_alu, wb_inst, wb_mmio, wb_mmio_rdata
    );

    modport master (
        output mem_pc, mem_alu, mem_rd2, mem_inst, mem_br_suc,
        output uart_tx_ready, uart_rx_data, uart_rx_valid,
        input  dmem_en, dmem_we, dmem_addr, dmem_din,
        input  uart_tx_data, uart_tx_valid, uart_rx_ready,
        input  wb_pc, wb_alu, wb_inst, wb_mmio, wb_mmio_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// mem_stage: RV32I MEM stage - DMEM drive, MMIO decode (UART, perf counters), MEM->WB registers.
// Optional feature macro BRANCH_STATS_EN builds the branch / correct-branch counters (0x1C / 0x20).
module mem_stage #(
    parameter int          DMEM_AW   = 14,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  wire logic  clk,
    input  wire logic  rst,
    mem_stage_if.slave mem_if
);
    localparam logic [6:0]  OP_LOAD     = 7'b0000011;
    localparam logic [6:0]  OP_STORE    = 7'b0100011;
    localparam logic [27:0] OFF_STATUS  = 28'h000_0000;
    localparam logic [27:0] OFF_RXDATA  = 28'h000_0004;
    localparam logic [27:0] OFF_TXDATA  = 28'h000_0008;
    localparam logic [27:0] OFF_CYCLE   = 28'h000_0010;
    localparam logic [27:0] OFF_INSTRET = 28'h000_0014;
    localparam logic [27:0] OFF_CNTRST  = 28'h000_0018;

    logic [31:0] addr;
    logic [31:0] rd2;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [1:0]  size;
    logic [27:0] offset;
    logic        is_load;
    logic        is_store;
    logic        is_mmio;
    logic        mmio_rd;
    logic        mmio_wr;
    logic        tx_wr;
    logic        cnt_clr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_din;
    logic [31:0] mmio_rdata;

    logic        tx_pend_q,  tx_pend_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic [31:0] cycle_q,    cycle_d;
    logic [31:0] instret_q,  instret_d;
    logic [31:0] wb_pc_q;
    logic [31:0] wb_alu_q;
    logic [31:0] wb_inst_q;
    logic        wb_mmio_q;
    logic [31:0] wb_mmio_rdata_q;

    assign addr     = mem_if.mem_alu;
    assign rd2      = mem_if.mem_rd2;
    assign inst     = mem_if.mem_inst;
    assign opcode   = inst[6:0];
    assign size     = inst[13:12];
    assign offset   = addr[27:0];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_mmio  = (addr[31:28] == MMIO_BASE[31:28]);
    assign mmio_rd  = is_load & is_mmio;
    assign mmio_wr  = is_store & is_mmio;
    assign tx_wr    = mmio_wr && (offset == OFF_TXDATA);
    assign cnt_clr  = mmio_wr && (offset == OFF_CNTRST);

    // Byte lanes: sub-word stores replicate the data so the enabled lane always sees it.
    always_comb begin
        dmem_we  = 4'b0000;
        dmem_din = rd2;
        if (is_store && !is_mmio) begin
            case (size)
                2'b00: begin
                    dmem_we  = 4'b0001 << addr[1:0];
                    dmem_din = {4{rd2[7:0]}};
                end
                2'b01: begin
                    dmem_we  = 4'b0011 << {addr[1], 1'b0};
                    dmem_din = {2{rd2[15:0]}};
                end
                2'b10:   dmem_we = 4'b1111;
                default: dmem_we = 4'b0000;
            endcase
        end
    end

    assign mem_if.dmem_en       = (is_load | is_store) & ~is_mmio;
    assign mem_if.dmem_we       = dmem_we;
    assign mem_if.dmem_addr     = addr[DMEM_AW+1:2];
    assign mem_if.dmem_din      = dmem_din;
    assign mem_if.uart_rx_ready = mmio_rd && (offset == OFF_RXDATA) && mem_if.uart_rx_valid;

    always_comb begin
        tx_pend_d = tx_pend_q;
        tx_data_d = tx_data_q;
        if (tx_pend_q && mem_if.uart_tx_ready) begin
            tx_pend_d = 1'b0;
        end
        // A write while a byte is still pending is dropped, even if it drains this edge.
        if (tx_wr && !tx_pend_q) begin
            tx_pend_d = 1'b1;
            tx_data_d = rd2[7:0];
        end
    end

    always_comb begin
        cycle_d   = cycle_q + 32'd1;
        instret_d = instret_q + {31'd0, (inst != NOP_INST)};
        if (cnt_clr) begin
            cycle_d   = '0;
            instret_d = '0;
        end
    end

`ifdef BRANCH_STATS_EN
    localparam logic [6:0]  OP_BRANCH  = 7'b1100011;
    localparam logic [27:0] OFF_BRANCH = 28'h000_001C;
    localparam logic [27:0] OFF_BRCORR = 28'h000_0020;

    logic        is_branch;
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] br_ok_q,  br_ok_d;

    assign is_branch = (opcode == OP_BRANCH);

    always_comb begin
        br_cnt_d = br_cnt_q + {31'd0, is_branch};
        br_ok_d  = br_ok_q + {31'd0, (is_branch & mem_if.mem_br_suc)};
        if (cnt_clr) begin
            br_cnt_d = '0;
            br_ok_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q <= '0;
            br_ok_q  <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            br_ok_q  <= br_ok_d;
        end
    end
`else
    logic unused_br_suc;
    assign unused_br_suc = mem_if.mem_br_suc;
`endif

    always_comb begin
        mmio_rdata = '0;
        case (offset)
            OFF_STATUS:  mmio_rdata = {30'd0, mem_if.uart_rx_valid, ~tx_pend_q};
            OFF_RXDATA:  mmio_rdata = {24'd0, mem_if.uart_rx_data};
            OFF_CYCLE:   mmio_rdata = cycle_q;
            OFF_INSTRET: mmio_rdata = instret_q;
`ifdef BRANCH_STATS_EN
            OFF_BRANCH:  mmio_rdata = br_cnt_q;
            OFF_BRCORR:  mmio_rdata = br_ok_q;
`endif
            default:     mmio_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_pend_q       <= 1'b0;
            tx_data_q       <= '0;
            cycle_q         <= '0;
            instret_q       <= '0;
            wb_pc_q         <= '0;
            wb_alu_q        <= '0;
            wb_inst_q       <= NOP_INST;
            wb_mmio_q       <= 1'b0;
            wb_mmio_rdata_q <= '0;
        end else begin
            tx_pend_q       <= tx_pend_d;
            tx_data_q       <= tx_data_d;
            cycle_q         <= cycle_d;
            instret_q       <= instret_d;
            wb_pc_q         <= mem_if.mem_pc;
            wb_alu_q        <= addr;
            wb_inst_q       <= inst;
            wb_mmio_q       <= mmio_rd;
            wb_mmio_rdata_q <= mmio_rd ? mmio_rdata : '0;
        end
    end

    assign mem_if.uart_tx_valid = tx_pend_q;
    assign mem_if.uart_tx_data  = tx_data_q;
    assign mem_if.wb_pc         = wb_pc_q;
    assign mem_if.wb_alu        = wb_alu_q;
    assign mem_if.wb_inst       = wb_inst_q;
    assign mem_if.wb_mmio       = wb_mmio_q;
    assign mem_if.wb_mmio_rdata = wb_mmio_rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// tb_mem_stage: directed self-checking bench for mem_stage (DMEM lanes, UART MMIO, counters, async reset).
module tb_mem_stage;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADD  = 32'h0000_0033;
    localparam logic [31:0] SB   = 32'h0000_0023;
    localparam logic [31:0] SH   = 32'h0000_1023;
    localparam logic [31:0] SW   = 32'h0000_2023;
    localparam logic [31:0] LW   = 32'h0000_2003;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] MMIO = 32'h8000_0000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_stage_if #(.DMEM_AW(14)) bus ();

    mem_stage dut (
        .clk    (clk),
        .rst    (rst),
        .mem_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction to MEM for the coming cycle.
    task automatic step(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rd2,
                        input logic [31:0] inst, input logic br);
        @(negedge clk);
        bus.mem_pc     = pc;
        bus.mem_alu    = alu;
        bus.mem_rd2    = rd2;
        bus.mem_inst   = inst;
        bus.mem_br_suc = br;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.mem_pc = '0; bus.mem_alu = '0; bus.mem_rd2 = '0; bus.mem_inst = NOP; bus.mem_br_suc = 1'b0;
        bus.uart_tx_ready = 1'b0; bus.uart_rx_data = '0; bus.uart_rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.wb_inst !== NOP) begin errors++; $display("FAIL reset_wb_inst got %h exp %h", bus.wb_inst, NOP); end
        checks++; if (bus.wb_pc !== 32'd0 || bus.wb_alu !== 32'd0) begin errors++; $display("FAIL reset_wb_pc_alu got %h/%h exp 0/0", bus.wb_pc, bus.wb_alu); end
        checks++; if (bus.wb_mmio !== 1'b0 || bus.wb_mmio_rdata !== 32'd0) begin errors++; $display("FAIL reset_wb_mmio got %b/%h exp 0/0", bus.wb_mmio, bus.wb_mmio_rdata); end
        checks++; if (bus.uart_tx_valid !== 1'b0 || bus.uart_tx_data !== 8'd0) begin errors++; $display("FAIL reset_tx got %b/%h exp 0/00", bus.uart_tx_valid, bus.uart_tx_data); end
        @(negedge clk);
        rst = 1'b1;
        step(32'h0, MMIO + 32'h14, 32'h0, LW, 1'b0);
        after_edge();
        checks++; if (bus.wb_mmio_rdata !== 32'd0) begin errors++; $display("FAIL reset_instret got %h exp 0", bus.wb_mmio_rdata); end
    endtask

    task automatic test_dmem();
        step(32'h40, 32'h1000_0006, 32'h1234_56AB, SB, 1'b0);
        #1;
        checks++; if (bus.dmem_en !== 1'b1 || bus.dmem_we !== 4'b0100) begin errors++; $display("FAIL sb_en_we got %b/%b exp 1/0100", bus.dmem_en, bus.dmem_we); end
        checks++; if (bus.dmem_din !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_din got %h exp ababab ab", bus.dmem_din); end
        checks++; if (bus.dmem_addr !== 14'h0001) begin errors++; $display("FAIL sb_addr got %h exp 0001", bus.dmem_addr); end
        after_edge();
        checks++; if (bus.wb_pc !== 32'h40 || bus.wb_alu !== 32'h1000_0006 || bus.wb_inst !== SB || bus.wb_mmio !== 1'b0) begin
            errors++; $display("FAIL sb_wb got %h/%h/%h/%b exp 00000040/10000006/%h/0", bus.wb_pc, bus.wb_alu, bus.wb_inst, bus.wb_mmio, SB); end
        step(32'h44, 32'h0000_0107, 32'h1234_56AB, SH, 1'b0);
        #1;
        checks++; if (bus.dmem_we !== 4'b1100 || bus.dmem_din !== 32'h56AB_56AB) begin errors++; $display("FAIL sh_we_din got %b/%h exp 1100/56ab56ab", bus.dmem_we, bus.dmem_din); end
        checks++; if (bus.dmem_addr !== 14'h0041) begin errors++; $display("FAIL sh_addr got %h exp 0041", bus.dmem_addr); end
        step(32'h48, 32'h0000_0013, 32'hDEAD_BEEF, SW, 1'b0);
        #1;
        checks++; if (bus.dmem_we !== 4'b1111 || bus.dmem_din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_we_din got %b/%h exp 1111/deadbeef", bus.dmem_we, bus.dmem_din); end
        step(32'h4C, 32'h0000_0020, 32'hFFFF_FFFF, LW, 1'b0);
        #1;
        checks++; if (bus.dmem_en !== 1'b1 || bus.dmem_we !== 4'b0000) begin errors++; $display("FAIL lw_dmem got %b/%b exp 1/0000", bus.dmem_en, bus.dmem_we); end
        step(32'h50, MMIO + 32'h40, 32'h0, SW, 1'b0);
        #1;
        checks++; if (bus.dmem_en !== 1'b0 || bus.dmem_we !== 4'b0000) begin errors++; $display("FAIL mmio_store_dmem got %b/%b exp 0/0000", bus.dmem_en, bus.dmem_we); end
    endtask

    task automatic test_tx();
        bus.uart_tx_ready = 1'b0;
        step(32'h60, MMIO + 32'h08, 32'h0000_0041, SW, 1'b0);
        after_edge();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.uart_tx_valid !== 1'b1 || bus.uart_tx_data !== 8'h41) begin errors++; $display("FAIL tx_hold%0d got %b/%h exp 1/41", i, bus.uart_tx_valid, bus.uart_tx_data); end
            step(32'h64, 32'h0, 32'h0, NOP, 1'b0);
            after_edge();
        end
        step(32'h68, MMIO + 32'h00, 32'h0, LW, 1'b0);
        after_edge();
        checks++; if (bus.wb_mmio !== 1'b1 || bus.wb_mmio_rdata !== 32'd0) begin errors++; $display("FAIL tx_status_busy got %b/%h exp 1/0", bus.wb_mmio, bus.wb_mmio_rdata); end
        step(32'h6C, MMIO + 32'h08, 32'h0000_0042, SW, 1'b0);
        after_edge();
        checks++; if (bus.uart_tx_data !== 8'h41 || bus.uart_tx_valid !== 1'b1) begin errors++; $display("FAIL tx_drop got %b/%h exp 1/41", bus.uart_tx_valid, bus.uart_tx_data); end
        step(32'h70, 32'h0, 32'h0, NOP, 1'b0);
        bus.uart_tx_ready = 1'b1;
        after_edge();
        bus.uart_tx_ready = 1'b0;
        checks++; if (bus.uart_tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drain got %b exp 0", bus.uart_tx_valid); end
        step(32'h74, MMIO + 32'h00, 32'h0, LW, 1'b0);
        after_edge();
        checks++; if (bus.wb_mmio_rdata !== 32'd1) begin errors++; $display("FAIL tx_status_idle got %h exp 1", bus.wb_mmio_rdata); end
    endtask

    task automatic test_rx();
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'h5A;
        step(32'h80, MMIO + 32'h04, 32'h0, LW, 1'b0);
        #1;
        checks++; if (bus.uart_rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready got %b exp 1", bus.uart_rx_ready); end
        after_edge();
        checks++; if (bus.wb_mmio !== 1'b1 || bus.wb_mmio_rdata !== 32'h5A) begin errors++; $display("FAIL rx_data got %b/%h exp 1/5a", bus.wb_mmio, bus.wb_mmio_rdata); end
        step(32'h84, MMIO + 32'h00, 32'h0, LW, 1'b0);
        after_edge();
        checks++; if (bus.wb_mmio_rdata !== 32'd3) begin errors++; $display("FAIL rx_status got %h exp 3", bus.wb_mmio_rdata); end
        bus.uart_rx_valid = 1'b0;
        step(32'h88, MMIO + 32'h04, 32'h0, LW, 1'b0);
        #1;
        checks++; if (bus.uart_rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_empty got %b exp 0", bus.uart_rx_ready); end
        step(32'h8C, MMIO + 32'h40, 32'h0, LW, 1'b0);
        after_edge();
        checks++; if (bus.wb_mmio !== 1'b1 || bus.wb_mmio_rdata !== 32'd0) begin errors++; $display("FAIL unmapped_read got %b/%h exp 1/0", bus.wb_mmio, bus.wb_mmio_rdata); end
    endtask

    task automatic test_counters();
        step(32'h90, MMIO + 32'h18, 32'h0, SW, 1'b0);
        for (int i = 0; i < 10; i++) step(32'h94 + 32'(i * 4), 32'h0, 32'h0, ADD, 1'b0);
        for (int i = 0; i < 2; i++) step(32'h0, 32'h0, 32'h0, NOP, 1'b0);
        step(32'hC0, MMIO + 32'h14, 32'h0, LW, 1'b0);
        after_edge();
        checks++; if (bus.wb_mmio_rdata !== 32'd10) begin errors++; $display("FAIL instret_count got %0d exp 10", bus.wb_mmio_rdata); end
        step(32'hC4, MMIO + 32'h18, 32'h0, SW, 1'b0);
        step(32'hC8, MMIO + 32'h10, 32'h0, LW, 1'b0);
        after_edge();
        checks++; if (bus.wb_mmio_rdata !== 32'd0) begin errors++; $display("FAIL cycle_clear got %0d exp 0", bus.wb_mmio_rdata); end
        step(32'hCC, MMIO + 32'h18, 32'h0, SW, 1'b0);
        step(32'hD0, MMIO + 32'h14, 32'h0, LW, 1'b0);
        after_edge();
        checks++; if (bus.wb_mmio_rdata !== 32'd0) begin errors++; $display("FAIL instret_clear got %0d exp 0", bus.wb_mmio_rdata); end
        step(32'hD4, MMIO + 32'h18, 32'h0, SW, 1'b0);
        for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 32'h0, NOP, 1'b0);
        step(32'hD8, MMIO + 32'h10, 32'h0, LW, 1'b0);
        after_edge();
        checks++; if (bus.wb_mmio_rdata !== 32'd3) begin errors++; $display("FAIL cycle_count got %0d exp 3", bus.wb_mmio_rdata); end
    endtask

    task automatic test_branch();
        logic [31:0] exp_br;
        logic [31:0] exp_ok;
`ifdef BRANCH_STATS_EN
        exp_br = 32'd4;
        exp_ok = 32'd3;
`else
        exp_br = 32'd0;
        exp_ok = 32'd0;
`endif
        step(32'hE0, MMIO + 32'h18, 32'h0, SW, 1'b0);
        step(32'hE4, 32'h0, 32'h0, BEQ, 1'b1);
        step(32'hE8, 32'h0, 32'h0, BEQ, 1'b0);
        step(32'hEC, 32'h0, 32'h0, BEQ, 1'b1);
        step(32'hF0, 32'h0, 32'h0, BEQ, 1'b1);
        step(32'hF4, 32'h0, 32'h0, ADD, 1'b1);
        step(32'hF8, MMIO + 32'h1C, 32'h0, LW, 1'b0);
        after_edge();
        checks++; if (bus.wb_mmio_rdata !== exp_br) begin errors++; $display("FAIL branch_count got %0d exp %0d", bus.wb_mmio_rdata, exp_br); end
        step(32'hFC, MMIO + 32'h20, 32'h0, LW, 1'b0);
        after_edge();
        checks++; if (bus.wb_mmio_rdata !== exp_ok) begin errors++; $display("FAIL branch_correct got %0d exp %0d", bus.wb_mmio_rdata, exp_ok); end
    endtask

    task automatic test_async_reset();
        bus.uart_tx_ready = 1'b0;
        step(32'h100, MMIO + 32'h08, 32'h0000_0077, SW, 1'b0);
        step(32'h104, 32'h1234, 32'h0, ADD, 1'b0);
        after_edge();
        checks++; if (bus.uart_tx_valid !== 1'b1 || bus.wb_inst !== ADD) begin errors++; $display("FAIL pre_reset got %b/%h exp 1/%h", bus.uart_tx_valid, bus.wb_inst, ADD); end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.wb_inst !== NOP || bus.wb_pc !== 32'd0 || bus.wb_alu !== 32'd0) begin
            errors++; $display("FAIL async_reset_wb got %h/%h/%h exp 00000013/0/0", bus.wb_inst, bus.wb_pc, bus.wb_alu); end
        checks++; if (bus.uart_tx_valid !== 1'b0 || bus.uart_tx_data !== 8'd0) begin errors++; $display("FAIL async_reset_tx got %b/%h exp 0/00", bus.uart_tx_valid, bus.uart_tx_data); end
        bus.mem_inst = NOP;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_dmem();
        test_tx();
        test_rx();
        test_counters();
        test_branch();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
